// File: rtl/mem_access_sequencer_pkg.sv
// Shared definitions for the memory access sequencer.
//   state_e      : sequencer FSM states
//   CS_RAM/ROM   : memChipSelect encoding
//   OP_READ/WRITE: memOpSelect encoding
//   CNT_W        : wait counter width (covers WAIT_CYCLES up to 15)
package mem_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_ACCESS  = 2'd2,
    ST_RECOVER = 2'd3
  } state_e;

  localparam logic CS_RAM   = 1'b0;
  localparam logic CS_ROM   = 1'b1;
  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_access_sequencer_if.sv
// Bundle of requester-side and memory-controller-side signals of the sequencer.
//   slave  : the sequencer (samples requests, drives acks and mem* fields)
//   master : requesters plus the RAM/ROM controller model
// Requester side : req0/1, addr0/1, wdata0/1, we0/1, cs0/1, byte0/1 -> ack0/1, rdata, ready
// Memory side    : memAddr, memWrData, memChipSelect, memLengthSelect, memOpSelect,
//                  memEnable, memDrive -> controller; memRdData <- controller
interface mem_seq_if
  import mem_seq_pkg::*;
#(
  parameter int ADDRESS_SIZE = 24,
  parameter int DATA_SIZE    = 16
);

  logic                    req0, req1;
  logic [ADDRESS_SIZE-1:0] addr0, addr1;
  logic [DATA_SIZE-1:0]    wdata0, wdata1;
  logic                    we0, we1;
  logic                    cs0, cs1;
  logic                    byte0, byte1;
  logic                    ack0, ack1;
  logic [DATA_SIZE-1:0]    rdata;
  logic                    ready;

  logic [ADDRESS_SIZE-1:0] memAddr;
  logic [DATA_SIZE-1:0]    memWrData;
  logic                    memChipSelect;
  logic                    memLengthSelect;
  logic                    memOpSelect;
  logic                    memEnable;
  logic                    memDrive;
  logic [DATA_SIZE-1:0]    memRdData;

  modport slave (
    input  req0, req1, addr0, addr1, wdata0, wdata1, we0, we1,
           cs0, cs1, byte0, byte1, memRdData,
    output ack0, ack1, rdata, ready, memAddr, memWrData, memChipSelect,
           memLengthSelect, memOpSelect, memEnable, memDrive
  );

  modport master (
    output req0, req1, addr0, addr1, wdata0, wdata1, we0, we1,
           cs0, cs1, byte0, byte1, memRdData,
    input  ack0, ack1, rdata, ready, memAddr, memWrData, memChipSelect,
           memLengthSelect, memOpSelect, memEnable, memDrive
  );

endinterface

// File: rtl/mem_access_sequencer_arb.sv
// Two-requester grant selection for the memory access sequencer.
//   req0_i, req1_i : level requests
//   last_grant_i   : requester granted most recently (0/1)
//   grant_o        : index of the requester to serve (0/1); 0 when idle
// Build option RR_ARBITRATION_EN: defined -> simultaneous requests alternate
// away from last_grant_i; undefined -> requester 0 always wins a tie.
module mem_rr_arbiter
  import mem_seq_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  output logic grant_o
);

`ifdef RR_ARBITRATION_EN
  always_comb begin
    grant_o = 1'b0;
    if (req0_i && req1_i) begin
      grant_o = ~last_grant_i;
    end else if (req1_i) begin
      grant_o = 1'b1;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;

  always_comb begin
    grant_o = 1'b0;
    if (req1_i && !req0_i) begin
      grant_o = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/mem_access_sequencer.sv
// Sequences one RAM/ROM access at a time for two requesters:
// IDLE -> SETUP (1 cycle) -> ACCESS (WAIT_CYCLES cycles) -> RECOVER (ack) -> IDLE.
//   clk, rst : single clock, asynchronous active-high reset
//   bus      : mem_seq_if.slave (requests/acks/rdata/ready and mem* controller fields)
// Build option RR_ARBITRATION_EN selects round-robin tie breaking in mem_rr_arbiter.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | ready high, requests sampled and latched on leaving
// ST_SETUP   | memEnable high, fields stable, wait counter loaded
// ST_ACCESS  | memEnable high, memDrive high for writes, counter runs down
// ST_RECOVER | ack to the granted requester, back to IDLE next cycle
module mem_access_sequencer
  import mem_seq_pkg::*;
#(
  parameter int ADDRESS_SIZE = 24,
  parameter int DATA_SIZE    = 16,
  parameter int WAIT_CYCLES  = 4
)
(
  input  logic     clk,
  input  logic     rst,
  mem_seq_if.slave bus
);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    load_en;
  logic                    capture_en;
  logic                    arb_grant;

  logic                    grant_q;
  logic                    last_grant_q;
  logic [ADDRESS_SIZE-1:0] addr_q;
  logic [DATA_SIZE-1:0]    wdata_q;
  logic                    we_q;
  logic                    cs_q;
  logic                    byte_q;
  logic [DATA_SIZE-1:0]    rdata_q;

  mem_rr_arbiter u_arb (
    .req0_i       (bus.req0),
    .req1_i       (bus.req1),
    .last_grant_i (last_grant_q),
    .grant_o      (arb_grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load_en    = 1'b0;
    capture_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_d = ST_SETUP;
          load_en = 1'b1;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          state_d    = ST_RECOVER;
          capture_en = (we_q == OP_READ);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RECOVER: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Transaction fields are captured only when leaving IDLE, so requester
  // inputs may change freely while a transaction is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= OP_READ;
      cs_q         <= CS_RAM;
      byte_q       <= 1'b0;
      rdata_q      <= '0;
    end else begin
      if (load_en) begin
        grant_q <= arb_grant;
        addr_q  <= arb_grant ? bus.addr1  : bus.addr0;
        wdata_q <= arb_grant ? bus.wdata1 : bus.wdata0;
        we_q    <= arb_grant ? bus.we1    : bus.we0;
        cs_q    <= arb_grant ? bus.cs1    : bus.cs0;
        byte_q  <= arb_grant ? bus.byte1  : bus.byte0;
`ifdef RR_ARBITRATION_EN
        last_grant_q <= arb_grant;
`endif
      end
      if (capture_en) begin
        rdata_q <= bus.memRdData;
      end
    end
  end

  // Strobes decode straight from the state register so an asynchronous
  // reset removes memDrive/memEnable without waiting for a clock edge.
  assign bus.ready           = (state_q == ST_IDLE);
  assign bus.memEnable       = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign bus.memDrive        = (state_q == ST_ACCESS) && (we_q == OP_WRITE);
  assign bus.ack0            = (state_q == ST_RECOVER) && !grant_q;
  assign bus.ack1            = (state_q == ST_RECOVER) && grant_q;
  assign bus.rdata           = rdata_q;
  assign bus.memAddr         = addr_q;
  assign bus.memWrData       = wdata_q;
  assign bus.memChipSelect   = cs_q;
  assign bus.memLengthSelect = byte_q;
  assign bus.memOpSelect     = we_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer with WAIT_CYCLES = 4.
// Inputs are driven and outputs sampled on the falling clock edge.
// Latency is counted in falling edges after the request is raised: the
// first one falls in SETUP, so the ack shows up on falling edge 6.
module tb_mem_access_sequencer;
  import mem_seq_pkg::*;

  localparam int AW = 24;
  localparam int DW = 16;
  localparam int WC = 4;

  logic clk;
  logic rst;

  int n_checks;
  int n_fail;

  mem_seq_if #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW)) bus ();

  mem_access_sequencer #(
    .ADDRESS_SIZE (AW),
    .DATA_SIZE    (DW),
    .WAIT_CYCLES  (WC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(output int who, output int lat, output int drv);
    who = -1;
    lat = 0;
    drv = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.memDrive) drv++;
      if (bus.ack0 || bus.ack1) begin
        check("ack_onehot", {31'd0, bus.ack0 && bus.ack1}, 32'd0);
        who = bus.ack1 ? 1 : 0;
        lat = n;
        break;
      end
    end
    check("ack_seen", {31'd0, who != -1}, 32'd1);
  endtask

  initial begin
    int who, lat, drv, acks, bad;
    int exp_order[4];

    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.req0 = 1'b0;  bus.req1 = 1'b0;
    bus.addr0 = '0;   bus.addr1 = '0;
    bus.wdata0 = '0;  bus.wdata1 = '0;
    bus.we0 = 1'b0;   bus.we1 = 1'b0;
    bus.cs0 = 1'b0;   bus.cs1 = 1'b0;
    bus.byte0 = 1'b0; bus.byte1 = 1'b0;
    bus.memRdData = '0;

    repeat (3) @(negedge clk);
    check("rst_ready",     {31'd0, bus.ready},     32'd1);
    check("rst_ack0",      {31'd0, bus.ack0},      32'd0);
    check("rst_ack1",      {31'd0, bus.ack1},      32'd0);
    check("rst_memEnable", {31'd0, bus.memEnable}, 32'd0);
    check("rst_memDrive",  {31'd0, bus.memDrive},  32'd0);
    check("rst_rdata",     {16'd0, bus.rdata},     32'd0);
    check("rst_memAddr",   {8'd0, bus.memAddr},    32'd0);
    rst = 1'b0;

    // RAM word read from requester 0
    @(negedge clk);
    bus.addr0 = 24'h000010; bus.we0 = OP_READ; bus.cs0 = CS_RAM; bus.byte0 = 1'b0;
    bus.memRdData = 16'hBEEF;
    bus.req0 = 1'b1;
    wait_ack(who, lat, drv);
    check("t1_who",      who, 0);
    check("t1_latency",  lat, WC + 2);
    check("t1_rdata",    {16'd0, bus.rdata}, 32'h0000BEEF);
    check("t1_drive",    drv, 0);
    check("t1_memAddr",  {8'd0, bus.memAddr}, 32'h00000010);
    check("t1_op",       {31'd0, bus.memOpSelect}, 32'd0);
    check("t1_cs",       {31'd0, bus.memChipSelect}, 32'd0);
    bus.req0 = 1'b0;
    @(negedge clk);
    check("t1_ready_after", {31'd0, bus.ready}, 32'd1);
    check("t1_ack0_after",  {31'd0, bus.ack0},  32'd0);

    // ROM byte write from requester 1; rdata must keep the previous read
    bus.memRdData = 16'h5555;
    bus.addr1 = 24'h00FF00; bus.wdata1 = 16'h00A5;
    bus.we1 = OP_WRITE; bus.cs1 = CS_ROM; bus.byte1 = 1'b1;
    bus.req1 = 1'b1;
    wait_ack(who, lat, drv);
    check("t2_who",      who, 1);
    check("t2_latency",  lat, WC + 2);
    check("t2_drive",    drv, WC);
    check("t2_len",      {31'd0, bus.memLengthSelect}, 32'd1);
    check("t2_cs",       {31'd0, bus.memChipSelect}, 32'd1);
    check("t2_op",       {31'd0, bus.memOpSelect}, 32'd1);
    check("t2_wdata",    {16'd0, bus.memWrData}, 32'h000000A5);
    check("t2_memAddr",  {8'd0, bus.memAddr}, 32'h0000FF00);
    check("t2_rdata",    {16'd0, bus.rdata}, 32'h0000BEEF);
    bus.req1 = 1'b0;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.ack1) acks++;
    end
    check("t2_ack1_once", acks, 0);

    // Both requesters held high for four transactions
`ifdef RR_ARBITRATION_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    bus.addr0 = 24'h000100; bus.addr1 = 24'h000200;
    bus.we0 = OP_READ; bus.we1 = OP_READ;
    bus.cs0 = CS_RAM;  bus.cs1 = CS_RAM;
    bus.byte0 = 1'b0;  bus.byte1 = 1'b0;
    bus.req0 = 1'b1;   bus.req1 = 1'b1;
    for (int t = 0; t < 4; t++) begin
      wait_ack(who, lat, drv);
      check($sformatf("t3_grant%0d", t), who, exp_order[t]);
      check($sformatf("t3_gap%0d", t), lat, (t == 0) ? WC + 2 : WC + 3);
      check($sformatf("t3_addr%0d", t), {8'd0, bus.memAddr},
            (exp_order[t] == 0) ? 32'h00000100 : 32'h00000200);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during the second ACCESS cycle of a write
    bus.addr0 = 24'h000003; bus.wdata0 = 16'h0077; bus.we0 = OP_WRITE;
    bus.req0 = 1'b1;
    repeat (3) @(negedge clk);
    check("t4_drive_before", {31'd0, bus.memDrive}, 32'd1);
    rst = 1'b1;
    #1;
    check("t4_memEnable", {31'd0, bus.memEnable}, 32'd0);
    check("t4_ready",     {31'd0, bus.ready},     32'd1);
    check("t4_memDrive",  {31'd0, bus.memDrive},  32'd0);
    check("t4_memAddr",   {8'd0, bus.memAddr},    32'd0);
    bus.req0 = 1'b0;
    bus.we0 = OP_READ;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    acks = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1) acks++;
    end
    check("t4_no_ack", acks, 0);

    // Address change mid-transaction is ignored
    bus.addr0 = 24'h000001; bus.memRdData = 16'h1234;
    bus.req0 = 1'b1;
    bad = 0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 3) bus.addr0 = 24'h000002;
      if (bus.memEnable && bus.memAddr != 24'h000001) bad++;
      if (bus.ack0) begin
        lat = n;
        break;
      end
    end
    check("t5_latency",  lat, WC + 2);
    check("t5_addr_hold", bad, 0);
    check("t5_memAddr",  {8'd0, bus.memAddr}, 32'h00000001);
    check("t5_rdata",    {16'd0, bus.rdata}, 32'h00001234);
    bus.req0 = 1'b0;
    @(negedge clk);
    check("t5_ready_after", {31'd0, bus.ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
